// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial unsigned subtractor: D = A - B (mod 2^WIDTH), one bit per clock,
// LSB first, through a single full-subtractor cell. BO and Z let it double as
// a magnitude comparator (BO=1 -> A<B, Z=1 -> A==B).
//
// State table:
//   IDLE | waiting for start; outputs hold the last result
//   RUN  | one bit processed per edge; busy=1
//   DONE | single-cycle done pulse; start here restarts immediately
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   start  begin a subtraction (ignored while busy)
//   A, B   minuend / subtrahend, captured on the accepting edge
//   D      registered difference
//   BO     registered borrow out (A < B unsigned)
//   Z      registered zero flag of D
//   busy   high while a subtraction is in progress
//   done   one-cycle pulse after D/BO/Z update
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] D,
    output logic             BO,
    output logic             Z,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             br_next;
    logic             last;
    logic             accept;

    // Full-subtractor cell and control decode.
    always_comb begin
        a_bit    = a_sh[0];
        b_bit    = b_sh[0];
        d_bit    = a_bit ^ b_bit ^ br;
        br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
        res_next = {d_bit, res[WIDTH-1:1]};
        last     = (cnt == CW'(WIDTH - 1));
        accept   = start && (state != RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh <= '0;
            b_sh <= '0;
            res  <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            D    <= '0;
            BO   <= 1'b0;
            Z    <= 1'b0;
        end else if (accept) begin
            // D/BO/Z deliberately untouched: they keep the previous result.
            a_sh <= A;
            b_sh <= B;
            br   <= 1'b0;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            res  <= res_next;
            br   <= br_next;
            cnt  <= cnt + 1'b1;
            if (last) begin
                D  <= res_next;
                BO <= br_next;
                Z  <= (res_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
// Directed bench for serial_subtractor (WIDTH=4). Inputs change and outputs
// are sampled 1 ns after each rising edge.
module tb_serial_subtractor;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] D;
    logic       BO;
    logic       Z;
    logic       busy;
    logic       done;

    int total;
    int bad;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .D     (D),
        .BO    (BO),
        .Z     (Z),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start from IDLE, expect done after exactly WIDTH edges past the accept.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] exp_d, input logic exp_bo,
                          input logic exp_z, input string tag);
        A = a;
        B = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, " busy"}, 32'(busy), 1);
            chk({tag, " done_early"}, 32'(done), 0);
            tick();
        end
        chk({tag, " done"}, 32'(done), 1);
        chk({tag, " busy_end"}, 32'(busy), 0);
        chk({tag, " D"}, 32'(D), 32'(exp_d));
        chk({tag, " BO"}, 32'(BO), 32'(exp_bo));
        chk({tag, " Z"}, 32'(Z), 32'(exp_z));
        tick();
        chk({tag, " done_clear"}, 32'(done), 0);
        chk({tag, " idle"}, 32'(busy), 0);
    endtask

    int done_cnt;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        start = 1'b0;
        A     = 4'd0;
        B     = 4'd0;
        tick();
        tick();
        chk("rst D", 32'(D), 0);
        chk("rst BO", 32'(BO), 0);
        chk("rst Z", 32'(Z), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        reset = 1'b0;
        tick();

        // Basic and comparator cases.
        run_op(4'd9, 4'd3, 4'd6, 1'b0, 1'b0, "9-3");
        run_op(4'd3, 4'd9, 4'hA, 1'b1, 1'b0, "3-9");
        run_op(4'd5, 4'd5, 4'd0, 1'b0, 1'b1, "5-5");
        run_op(4'd0, 4'd15, 4'd1, 1'b1, 1'b0, "0-15");
        run_op(4'd15, 4'd0, 4'd15, 1'b0, 1'b0, "15-0");
        run_op(4'd0, 4'd0, 4'd0, 1'b0, 1'b1, "0-0");

        // Back-to-back with start held high.
        A = 4'd7;
        B = 4'd2;
        start = 1'b1;
        tick();
        A = 4'd2;
        B = 4'd7;
        for (int i = 0; i < 4; i++) begin
            chk("b2b1 busy", 32'(busy), 1);
            chk("b2b1 D_hold", 32'(D), 0);
            tick();
        end
        chk("b2b1 done", 32'(done), 1);
        chk("b2b1 D", 32'(D), 5);
        chk("b2b1 BO", 32'(BO), 0);
        tick();
        chk("b2b2 restart busy", 32'(busy), 1);
        chk("b2b2 done_clear", 32'(done), 0);
        for (int i = 0; i < 3; i++) begin
            chk("b2b2 D_hold", 32'(D), 5);
            tick();
            chk("b2b2 busy", 32'(busy), 1);
        end
        tick();
        chk("b2b2 done", 32'(done), 1);
        chk("b2b2 D", 32'(D), 11);
        chk("b2b2 BO", 32'(BO), 1);
        start = 1'b0;
        tick();
        chk("b2b idle busy", 32'(busy), 0);
        chk("b2b idle done", 32'(done), 0);

        // Reset aborts a run in progress.
        A = 4'd12;
        B = 4'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort D", 32'(D), 0);
        chk("abort BO", 32'(BO), 0);
        chk("abort Z", 32'(Z), 0);
        chk("abort busy", 32'(busy), 0);
        chk("abort done", 32'(done), 0);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) done_cnt++;
        end
        chk("abort no_done", 32'(done_cnt), 0);
        run_op(4'd12, 4'd4, 4'd8, 1'b0, 1'b0, "12-4");

        // Operand changes and start pulses during RUN have no effect.
        A = 4'd6;
        B = 4'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        A = 4'd0;
        B = 4'd15;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("midrun busy", 32'(busy), 1);
        tick();
        chk("midrun done", 32'(done), 1);
        chk("midrun D", 32'(D), 5);
        chk("midrun BO", 32'(BO), 0);
        chk("midrun Z", 32'(Z), 0);
        for (int i = 0; i < 10; i++) begin
            A = 4'(i);
            B = 4'(15 - i);
            tick();
            chk("hold D", 32'(D), 5);
            chk("hold BO", 32'(BO), 0);
            chk("hold Z", 32'(Z), 0);
            chk("hold busy", 32'(busy), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
